// File: rtl/prio_pkg.sv
// Shared definitions for the priority scan encoder: state encoding and
// an elaboration-time log2 helper used to size index ports.
package prio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_NONE = 2'd2
    } state_t;

    // Ceiling log2, minimum 1 so a 2-entry vector still gets a 1-bit index.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_scan_enc_if.sv
// Request-in / index-out handshake bundle for prio_scan_enc.
interface prio_scan_enc_if #(
    parameter int N = 8
);
    import prio_pkg::*;

    localparam int W = clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_none;
    logic [W:0]   out_cnt;

    modport master (
        output in_valid,
        input  in_ready,
        output in_vec,
        input  out_valid,
        output out_ready,
        input  out_idx,
        input  out_last,
        input  out_none,
        input  out_cnt
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_vec,
        output out_valid,
        input  out_ready,
        output out_idx,
        output out_last,
        output out_none,
        output out_cnt
    );

endinterface

// File: rtl/prio_enc_n.sv
// Combinational N-to-W fixed-priority encoder; generalisation of the
// 4-to-2 encoder with selectable LSB-first or MSB-first priority.
module prio_enc_n
    import prio_pkg::*;
#(
    parameter  int N         = 8,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int W         = clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         vld
);

    // The last match in each loop wins, so iterate from lowest to highest priority.
    always_comb begin
        idx = '0;
        vld = |vec;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    idx = W'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/prio_scan_enc.sv
// Sequential priority scanner: accepts a request vector and emits the index
// of every set bit, one beat per output handshake, in priority order.
module prio_scan_enc
    import prio_pkg::*;
#(
    parameter int N          = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit EMPTY_EMIT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    prio_scan_enc_if.slave  bus,
    output logic            busy
);

    localparam int W = clog2(N);

    state_t       state;
    logic [N-1:0] pend;
    logic [W:0]   cnt;

    logic [W-1:0] enc_idx;
    logic         enc_vld;
    logic         one_left;

    prio_enc_n #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .vec (pend),
        .idx (enc_idx),
        .vld (enc_vld)
    );

    // Clearing the lowest set bit leaves zero only when a single bit remains.
    assign one_left = ((pend & (pend - N'(1))) == '0);

    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        busy          = (state != ST_IDLE);
        bus.out_valid = 1'b0;
        bus.out_idx   = '0;
        bus.out_last  = 1'b0;
        bus.out_none  = 1'b0;
        bus.out_cnt   = '0;
        case (state)
            ST_SCAN: begin
                bus.out_valid = enc_vld;
                bus.out_idx   = enc_idx;
                bus.out_last  = one_left;
                bus.out_cnt   = cnt;
            end
            ST_NONE: begin
                bus.out_valid = 1'b1;
                bus.out_last  = 1'b1;
                bus.out_none  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pend  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_vec != '0) begin
                            pend  <= bus.in_vec;
                            cnt   <= '0;
                            state <= ST_SCAN;
                        end else if (EMPTY_EMIT) begin
                            state <= ST_NONE;
                        end
                    end
                end
                ST_SCAN: begin
                    if (bus.out_ready) begin
                        pend <= pend & ~(N'(1) << enc_idx);
                        cnt  <= cnt + (W + 1)'(1);
                        if (one_left) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_NONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_scan_enc.sv
// Bench for prio_scan_enc: three instances (LSB-first, MSB-first, LSB-first
// dropping empty vectors) share stimulus and are checked against a beat-queue model.
module tb_prio_scan_enc;
    import prio_pkg::*;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] in_vec;
    logic         out_ready;

    logic [NI-1:0] ir, ov, ol, on, bz;
    logic [W-1:0]  oi [NI];
    logic [W:0]    oc [NI];

    prio_scan_enc_if #(.N(N)) bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign bus[g].in_valid  = in_valid;
        assign bus[g].in_vec    = in_vec;
        assign bus[g].out_ready = out_ready;
        assign ir[g] = bus[g].in_ready;
        assign ov[g] = bus[g].out_valid;
        assign ol[g] = bus[g].out_last;
        assign on[g] = bus[g].out_none;
        assign oi[g] = bus[g].out_idx;
        assign oc[g] = bus[g].out_cnt;

        prio_scan_enc #(
            .N          (N),
            .MSB_FIRST  (g == 1),
            .EMPTY_EMIT (g != 2)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g]),
            .busy  (bz[g])
        );
    end

    // Reference model: per instance, the list of beats still owed, packed as
    // idx | last<<8 | none<<9 | cnt<<12.
    int q  [NI][16];
    int qn [NI];
    int compared   = 0;
    int mismatched = 0;
    int rdy_mode   = 0;
    bit noise      = 1'b0;

    function automatic int mk(int idx, int last, int none, int cnt);
        return idx | (last << 8) | (none << 9) | (cnt << 12);
    endfunction

    task automatic append(int inst, int beat);
        q[inst][qn[inst]] = beat;
        qn[inst] = qn[inst] + 1;
    endtask

    task automatic pop(int inst);
        for (int j = 0; j < 15; j++) q[inst][j] = q[inst][j + 1];
        qn[inst] = qn[inst] - 1;
    endtask

    task automatic push_vec(int inst, logic [N-1:0] v);
        int k;
        int pos;
        int b;
        k   = $countones(v);
        pos = 0;
        if (k == 0) begin
            if (inst != 2) append(inst, mk(0, 1, 1, 0));
        end else begin
            for (int j = 0; j < N; j++) begin
                b = (inst == 1) ? (N - 1 - j) : j;
                if (v[b]) begin
                    append(inst, mk(b, int'(pos == k - 1), 0, pos));
                    pos = pos + 1;
                end
            end
        end
    endtask

    function automatic bit all_idle();
        return (qn[0] == 0) && (qn[1] == 0) && (qn[2] == 0);
    endfunction

    task automatic chk(string tag, int inst, logic [31:0] obs, int expv);
        compared = compared + 1;
        assert (obs === 32'(expv)) else begin
            mismatched = mismatched + 1;
            $error("FAIL %s dut%0d: observed %0d, expected %0d", tag, inst, obs, expv);
        end
    endtask

    task automatic check_all();
        int e;
        bit empty;
        for (int i = 0; i < NI; i++) begin
            empty = (qn[i] == 0);
            e = empty ? 0 : q[i][0];
            chk("in_ready",  i, 32'(ir[i]), int'(empty));
            chk("out_valid", i, 32'(ov[i]), int'(!empty));
            chk("busy",      i, 32'(bz[i]), int'(!empty));
            chk("out_idx",   i, 32'(oi[i]), e & 255);
            chk("out_last",  i, 32'(ol[i]), (e >> 8) & 1);
            chk("out_none",  i, 32'(on[i]), (e >> 9) & 1);
            chk("out_cnt",   i, 32'(oc[i]), (e >> 12) & 15);
        end
    endtask

    // Inputs change at posedge+1, outputs are checked at posedge+2.
    task automatic cycle();
        #1;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) qn[i] = 0;
        end
        check_all();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                if (qn[i] > 0) begin
                    if (out_ready) pop(i);
                end else if (in_valid) begin
                    push_vec(i, in_vec);
                end
            end
        end
        #1;
    endtask

    task automatic set_ready();
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!all_idle() && n < 200) begin
            set_ready();
            if (noise) begin
                in_valid = $urandom_range(0, 1) == 1;
                in_vec   = N'($urandom);
            end
            cycle();
            n = n + 1;
        end
        in_valid = 1'b0;
        if (!all_idle()) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL drain_timeout: observed busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic send(logic [N-1:0] v);
        wait_idle();
        set_ready();
        in_valid = 1'b1;
        in_vec   = v;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [N-1:0] v;
        for (int i = 0; i < NI; i++) qn[i] = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        rdy_mode = 0;
        send(8'b1010_0100);
        wait_idle();
        cycle();

        rdy_mode = 1;
        noise    = 1'b1;
        send(8'hFF);
        wait_idle();
        noise    = 1'b0;

        rdy_mode = 0;
        send(8'h00);
        wait_idle();
        cycle();
        cycle();

        send(8'h81);
        out_ready = 1'b1;
        cycle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        send(8'h10);
        wait_idle();

        send(8'h80);
        wait_idle();

        rdy_mode = 2;
        repeat (30) begin
            v = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            send(v);
        end
        wait_idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
